// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// Memory stage of the pipelined MIPS core. It holds the EX/MEM pipeline
// register and runs a req/ack handshake toward data memory for loads and
// stores. While an access is outstanding it stalls the front of the pipeline.
// It also holds the MEM/WB register and selects the writeback result.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   When defined, a load or store whose address has bits [1:0] != 0 issues no
//   request and completes in the same cycle. The store is dropped and the load
//   writes back 0. The sticky misalign_err output is then present.
//   When undefined, misalign_err does not exist and the address is passed
//   through unchecked.
//
// Parameters
//   TIMEOUT     wait-state cycles allowed before an access is abandoned (>= 1)
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   RegWriteE, MemWriteE,
//   MemtoRegE, WriteRegE,
//   ALUOutE, WriteDataE,
//   PCPlus4E                  control and results from execute
//   ALUOutM, WriteRegM,
//   RegWriteM, MemtoRegM      EX/MEM contents (forwarding and hazard unit)
//   StallM                    access outstanding; F/D/E must freeze
//   dmem_req, dmem_we,
//   dmem_addr, dmem_wdata     request toward data memory
//   dmem_rdata, dmem_ack      response from data memory
//   RegWriteW, WriteRegW,
//   ResultW                   MEM/WB writeback
//   bus_err                   sticky access-timeout flag
//   misalign_err              sticky misaligned-access flag (macro builds only)
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  MemtoRegE,
  input  logic [4:0]  WriteRegE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic [1:0]  MemtoRegM,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic        bus_err
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // The counter only ever has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // EX/MEM register
  logic        r_regwrite_m;
  logic        r_memwrite_m;
  logic [1:0]  r_memtoreg_m;
  logic [4:0]  r_writereg_m;
  logic [31:0] r_aluout_m;
  logic [31:0] r_writedata_m;
  logic [31:0] r_pcplus4_m;

  // Handshake FSM
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;

  // MEM/WB register
  logic        r_regwrite_w;
  logic [1:0]  r_memtoreg_w;
  logic [4:0]  r_writereg_w;
  logic [31:0] r_aluout_w;
  logic [31:0] r_readdata_w;
  logic [31:0] r_pcplus4_w;

  logic        w_memop;
  logic        w_misalign;
  logic        w_req;
  logic        w_ack;
  logic        w_timeout;
  logic        w_complete;
  logic        w_stall;
  logic [31:0] w_load_data;

  assign w_memop = r_memwrite_m | (r_memtoreg_m == 2'b01);

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign_err;
  assign w_misalign   = w_memop & (r_aluout_m[1:0] != 2'b00);
  assign misalign_err = r_misalign_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else if (w_misalign) begin
      r_misalign_err <= 1'b1;
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  // In WAIT the EX/MEM register is frozen on the memory op, so the request
  // stays up. A misaligned op never reaches the bus.
  assign w_req      = (r_state == S_WAIT) | (w_memop & ~w_misalign);
  assign w_ack      = w_req & dmem_ack;
  // Fires in the TIMEOUT-th wait cycle, which makes the stall exactly TIMEOUT
  // cycles long (the completing cycle itself does not stall).
  assign w_timeout  = (r_state == S_WAIT) & ~dmem_ack & (r_cnt == CNT_LAST);
  assign w_complete = w_ack | w_timeout | w_misalign;
  assign w_stall    = w_memop & ~w_complete;

  assign w_load_data = w_timeout  ? TIMEOUT_DATA :
                       w_misalign ? 32'd0        : dmem_rdata;

  assign dmem_req   = w_req;
  assign dmem_we    = r_memwrite_m & w_req;
  assign dmem_addr  = r_aluout_m;
  assign dmem_wdata = r_writedata_m;
  assign StallM     = w_stall;
  assign bus_err    = r_bus_err;

  assign ALUOutM   = r_aluout_m;
  assign WriteRegM = r_writereg_m;
  assign RegWriteM = r_regwrite_m;
  assign MemtoRegM = r_memtoreg_m;

  assign RegWriteW = r_regwrite_w;
  assign WriteRegW = r_writereg_w;

  always_comb begin
    ResultW = r_aluout_w;
    case (r_memtoreg_w)
      2'b01:   ResultW = r_readdata_w;
      2'b10:   ResultW = r_pcplus4_w;
      default: ResultW = r_aluout_w;
    endcase
  end

  // EX/MEM register: holds while the current access is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite_m  <= 1'b0;
      r_memwrite_m  <= 1'b0;
      r_memtoreg_m  <= 2'b00;
      r_writereg_m  <= 5'd0;
      r_aluout_m    <= 32'd0;
      r_writedata_m <= 32'd0;
      r_pcplus4_m   <= 32'd0;
    end else if (!w_stall) begin
      r_regwrite_m  <= RegWriteE;
      r_memwrite_m  <= MemWriteE;
      r_memtoreg_m  <= MemtoRegE;
      r_writereg_m  <= WriteRegE;
      r_aluout_m    <= ALUOutE;
      r_writedata_m <= WriteDataE;
      r_pcplus4_m   <= PCPlus4E;
    end
  end

  // Handshake FSM and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !dmem_ack) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (w_complete) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // MEM/WB register: a stalled cycle inserts a bubble so the instruction
  // stuck in MEM is written back exactly once, on its completing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 2'b00;
      r_writereg_w <= 5'd0;
      r_aluout_w   <= 32'd0;
      r_readdata_w <= 32'd0;
      r_pcplus4_w  <= 32'd0;
    end else begin
      r_regwrite_w <= r_regwrite_m & ~w_stall;
      if (!w_stall) begin
        r_memtoreg_w <= r_memtoreg_m;
        r_writereg_w <= r_writereg_m;
        r_aluout_w   <= r_aluout_m;
        r_readdata_w <= w_load_data;
        r_pcplus4_w  <= r_pcplus4_m;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//
// Self-checking bench for memory_stage (TIMEOUT = 4). Inputs are driven 1 ns
// after the rising edge and outputs sampled on the falling edge. Expected
// writebacks are pushed to a scoreboard queue when the instruction is issued
// and popped when it reaches the W stage.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  MemtoRegE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUOutE, WriteDataE, PCPlus4E;
  logic [31:0] ALUOutM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM;
  logic [1:0]  MemtoRegM;
  logic        StallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        bus_err;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegE(WriteRegE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .PCPlus4E(PCPlus4E),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .StallM(StallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic rw, input logic mw, input logic [1:0] m2r,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
    RegWriteE  = rw;
    MemWriteE  = mw;
    MemtoRegE  = m2r;
    WriteRegE  = rd;
    ALUOutE    = alu;
    WriteDataE = wd;
    PCPlus4E   = pc4;
  endtask

  task automatic drive_nop();
    drive_e(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    drive_nop();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({ALUOutM, WriteRegM, RegWriteM, MemtoRegM} !== 40'd0) $display("FAIL reset_exmem got %h want 0", {ALUOutM, WriteRegM, RegWriteM, MemtoRegM}); else n_pass++;
    n_checks++; if ({StallM, dmem_req, dmem_we, bus_err, RegWriteW} !== 5'd0) $display("FAIL reset_ctrl got %b want 00000", {StallM, dmem_req, dmem_we, bus_err, RegWriteW}); else n_pass++;
    n_checks++; if ({dmem_addr, dmem_wdata, ResultW, WriteRegW} !== 101'd0) $display("FAIL reset_data got %h want 0", {dmem_addr, dmem_wdata, ResultW, WriteRegW}); else n_pass++;
    $display("reset: outputs sampled during reset");
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_zero_wait_load();
    sb_t e;
    drive_e(1'b1, 1'b0, 2'b01, 5'd5, 32'h10, 32'd0, 32'h104);
    sb_q.push_back('{rd: 5'd5, val: 32'h1234_5678});
    step();
    drive_nop();
    dmem_rdata = 32'h1234_5678;
    dmem_ack = 1'b1;
    @(negedge clk);
    n_checks++; if ({dmem_req, dmem_we, StallM} !== 3'b100) $display("FAIL zw_req got req/we/stall=%b want 100", {dmem_req, dmem_we, StallM}); else n_pass++;
    n_checks++; if (dmem_addr !== 32'h10) $display("FAIL zw_addr got %h want 00000010", dmem_addr); else n_pass++;
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++; if ({RegWriteW, WriteRegW} !== {1'b1, e.rd}) $display("FAIL zw_wb got we=%b rd=%0d want we=1 rd=%0d", RegWriteW, WriteRegW, e.rd); else n_pass++;
    n_checks++; if (ResultW !== e.val) $display("FAIL zw_result got %h want %h", ResultW, e.val); else n_pass++;
    n_checks++; if (StallM !== 1'b0) $display("FAIL zw_nostall got %b want 0", StallM); else n_pass++;
    $display("zero-wait load: addr=10 ResultW=%h rd=%0d", ResultW, WriteRegW);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_store_wait();
    sb_t e;
    int  stalls = 0;
    bit  done = 0;
    step();
    drive_e(1'b0, 1'b1, 2'b00, 5'd0, 32'h20, 32'hCAFE_F00D, 32'h204);
    step();
    drive_e(1'b1, 1'b0, 2'b00, 5'd7, 32'h77, 32'd0, 32'h208);
    sb_q.push_back('{rd: 5'd7, val: 32'h77});
    for (int k = 0; k < 12 && !done; k++) begin
      if (k > 0) step();
      dmem_ack = (k == 3);
      @(negedge clk);
      n_checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {2'b11, 32'h20, 32'hCAFE_F00D}) $display("FAIL st_bus cyc%0d got req=%b we=%b addr=%h data=%h want 1 1 00000020 cafef00d", k, dmem_req, dmem_we, dmem_addr, dmem_wdata); else n_pass++;
      if (StallM) begin
        stalls++;
        n_checks++; if ({RegWriteW, WriteRegM, ALUOutM} !== {1'b0, 5'd0, 32'h20}) $display("FAIL st_hold cyc%0d got wbwe=%b rdM=%0d aluM=%h want 0 0 00000020", k, RegWriteW, WriteRegM, ALUOutM); else n_pass++;
      end else begin
        done = 1;
      end
    end
    n_checks++; if (stalls !== 3) $display("FAIL st_stall_len got %0d want 3", stalls); else n_pass++;
    step();
    dmem_ack = 1'b0;
    drive_nop();
    @(negedge clk);
    n_checks++; if ({RegWriteM, WriteRegM, ALUOutM, RegWriteW} !== {1'b1, 5'd7, 32'h77, 1'b0}) $display("FAIL st_next got weM=%b rdM=%0d aluM=%h weW=%b want 1 7 00000077 0", RegWriteM, WriteRegM, ALUOutM, RegWriteW); else n_pass++;
    step();
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++; if ({RegWriteW, WriteRegW, ResultW} !== {1'b1, e.rd, e.val}) $display("FAIL st_follow_wb got we=%b rd=%0d res=%h want 1 %0d %h", RegWriteW, WriteRegW, ResultW, e.rd, e.val); else n_pass++;
    $display("store 3 wait: stalls=%0d follower ResultW=%h", stalls, ResultW);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    sb_t e;
    int  stalls = 0;
    bit  done = 0;
    step();
    drive_e(1'b1, 1'b0, 2'b01, 5'd9, 32'h30, 32'd0, 32'h304);
    sb_q.push_back('{rd: 5'd9, val: 32'hDEAD_BEEF});
    step();
    drive_nop();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h1111_1111;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) step();
      @(negedge clk);
      if (StallM) stalls++;
      else done = 1;
    end
    n_checks++; if (!done) $display("FAIL to_bound got no completion want completion within 20 cycles"); else n_pass++;
    n_checks++; if (stalls !== TO) $display("FAIL to_stall_len got %0d want %0d", stalls, TO); else n_pass++;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL to_err_early got %b want 0", bus_err); else n_pass++;
    step();
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++; if (bus_err !== 1'b1) $display("FAIL to_bus_err got %b want 1", bus_err); else n_pass++;
    n_checks++; if ({RegWriteW, WriteRegW, ResultW} !== {1'b1, e.rd, e.val}) $display("FAIL to_result got we=%b rd=%0d res=%h want 1 %0d %h", RegWriteW, WriteRegW, ResultW, e.rd, e.val); else n_pass++;
    n_checks++; if ({dmem_req, StallM} !== 2'b00) $display("FAIL to_idle got req/stall=%b want 00", {dmem_req, StallM}); else n_pass++;
    $display("timeout: stalls=%0d bus_err=%b ResultW=%h", stalls, bus_err, ResultW);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_link();
    sb_t e;
    step();
    drive_e(1'b1, 1'b0, 2'b10, 5'd31, 32'h55, 32'd0, 32'h404);
    sb_q.push_back('{rd: 5'd31, val: 32'h404});
    step();
    drive_nop();
    @(negedge clk);
    n_checks++; if ({dmem_req, StallM} !== 2'b00) $display("FAIL jal_noreq got req/stall=%b want 00", {dmem_req, StallM}); else n_pass++;
    step();
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++; if ({RegWriteW, WriteRegW, ResultW} !== {1'b1, e.rd, e.val}) $display("FAIL jal_result got we=%b rd=%0d res=%h want 1 %0d %h", RegWriteW, WriteRegW, ResultW, e.rd, e.val); else n_pass++;
    $display("link: ResultW=%h rd=%0d", ResultW, WriteRegW);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    sb_t e;
    step();
    drive_e(1'b1, 1'b0, 2'b01, 5'd3, 32'h40, 32'd0, 32'h504);
    sb_q.push_back('{rd: 5'd3, val: 32'h0BAD_F00D});
    step();
    drive_e(1'b0, 1'b1, 2'b00, 5'd0, 32'h44, 32'hA5A5_A5A5, 32'h508);
    dmem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if ({dmem_req, dmem_we, StallM, dmem_addr} !== {3'b101, 32'h40}) $display("FAIL b2b_ld_wait got req=%b we=%b stall=%b addr=%h want 1 0 1 00000040", dmem_req, dmem_we, StallM, dmem_addr); else n_pass++;
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    n_checks++; if ({dmem_req, StallM, dmem_addr} !== {2'b10, 32'h40}) $display("FAIL b2b_ld_ack got req=%b stall=%b addr=%h want 1 0 00000040", dmem_req, StallM, dmem_addr); else n_pass++;
    step();
    drive_nop();
    dmem_ack = 1'b0;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if ({dmem_req, dmem_we, StallM, dmem_addr, dmem_wdata} !== {3'b111, 32'h44, 32'hA5A5_A5A5}) $display("FAIL b2b_st_wait got req=%b we=%b stall=%b addr=%h data=%h want 1 1 1 00000044 a5a5a5a5", dmem_req, dmem_we, StallM, dmem_addr, dmem_wdata); else n_pass++;
    e = sb_q.pop_front();
    n_checks++; if ({RegWriteW, WriteRegW, ResultW} !== {1'b1, e.rd, e.val}) $display("FAIL b2b_ld_result got we=%b rd=%0d res=%h want 1 %0d %h", RegWriteW, WriteRegW, ResultW, e.rd, e.val); else n_pass++;
    step();
    dmem_ack = 1'b1;
    @(negedge clk);
    n_checks++; if ({dmem_req, dmem_we, StallM} !== 3'b110) $display("FAIL b2b_st_ack got req/we/stall=%b want 110", {dmem_req, dmem_we, StallM}); else n_pass++;
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if ({dmem_req, RegWriteW} !== 2'b00) $display("FAIL b2b_done got req/weW=%b want 00", {dmem_req, RegWriteW}); else n_pass++;
    $display("back-to-back: load ResultW=%h then store 44 done", e.val);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_in_wait();
    sb_t e;
    step();
    drive_e(1'b1, 1'b0, 2'b01, 5'd4, 32'h50, 32'd0, 32'h604);
    step();
    drive_nop();
    dmem_ack = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++; if ({dmem_req, StallM} !== 2'b11) $display("FAIL rw_in_wait got req/stall=%b want 11", {dmem_req, StallM}); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if ({dmem_req, StallM, RegWriteW, bus_err} !== 4'b0000) $display("FAIL rw_async got req/stall/weW/err=%b want 0000", {dmem_req, StallM, RegWriteW, bus_err}); else n_pass++;
    step();
    step();
    rst = 1'b0;
    drive_e(1'b1, 1'b0, 2'b01, 5'd6, 32'h60, 32'd0, 32'h704);
    sb_q.push_back('{rd: 5'd6, val: 32'h600D_D00D});
    step();
    drive_nop();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h600D_D00D;
    @(negedge clk);
    n_checks++; if ({dmem_req, StallM, dmem_addr} !== {2'b10, 32'h60}) $display("FAIL rw_next_req got req=%b stall=%b addr=%h want 1 0 00000060", dmem_req, StallM, dmem_addr); else n_pass++;
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++; if ({RegWriteW, WriteRegW, ResultW} !== {1'b1, e.rd, e.val}) $display("FAIL rw_next_result got we=%b rd=%0d res=%h want 1 %0d %h", RegWriteW, WriteRegW, ResultW, e.rd, e.val); else n_pass++;
    $display("reset in WAIT: discarded, next load ResultW=%h", ResultW);
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_timeout();
    test_link();
    test_back_to_back();
    test_reset_in_wait();
    n_checks++; if (sb_q.size() != 0) $display("FAIL sb_empty got %0d entries want 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
